vga_sync_decoder: RTL

Receive-side counterpart of the VGA timing generator: watches hsync/vsync/blank_n (from the driver or an external source) on the 50 MHz system clock, qualified by a pixel-rate enable. Recovers the current active-pixel coordinate, measures line length and frame height, and declares lock once the timing matches 640x480@60 for consecutive frames. Used as a loopback checker and as the front end for any block that consumes VGA-timed data.

---
 rtl/vga_sync_decoder_if.sv | 10 +
 rtl/vga_sync_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync bus into the VGA timing decoder: pixel strobe plus the three timing pins.
interface vga_sync_decoder_if;
    logic pix_en;
    logic hsync;
    logic vsync;
    logic blank_n;

    modport master (output pix_en, hsync, vsync, blank_n);
    modport slave  (input  pix_en, hsync, vsync, blank_n);
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame geometry from a VGA sync stream and
// declares lock. Define SYNC_ERR_COUNT_EN to add the saturating err_count output.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 0
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_decoder_if.slave vid,
    output logic [9:0]        x_pos,
    output logic [9:0]        y_pos,
    output logic              active,
    output logic [10:0]       line_len,
    output logic [9:0]        frame_lines,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_err
`ifdef SYNC_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);
    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] TMO_L   = 11'(2 * H_TOTAL);
    localparam logic [9:0]  V_TOT_L = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_L  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

    state_e      state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, bl_prev_q, bl_prev_d;
    logic [10:0] h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d, line_len_q, line_len_d;
    logic [9:0]  v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d, frame_lines_q, frame_lines_d;
    logic        active_q, active_d, frame_start_q, frame_start_d;
    logic        locked_q, locked_d, sync_err_q, sync_err_d, line_ok_q, line_ok_d;
    logic [3:0]  good_q, good_d;

    logic        hs_a, vs_a, hs_edge, vs_edge, bl_fall;
    logic        line_bad, frame_good, tmo;
    logic [10:0] h_inc;
    logic [9:0]  v_inc, y_inc;

    // Normalise sync pins so "1" always means asserted.
    assign hs_a    = (SYNC_POL != 0) ? vid.hsync : ~vid.hsync;
    assign vs_a    = (SYNC_POL != 0) ? vid.vsync : ~vid.vsync;
    assign hs_edge = vid.pix_en & hs_a & ~hs_prev_q;
    assign vs_edge = vid.pix_en & vs_a & ~vs_prev_q;
    assign bl_fall = vid.pix_en & ~vid.blank_n & bl_prev_q;
    assign h_inc   = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
    assign v_inc   = (hs_edge && v_cnt_q != 10'h3FF) ? v_cnt_q + 10'd1 : v_cnt_q;
    assign y_inc   = (bl_fall && y_q != 10'h3FF) ? y_q + 10'd1 : y_q;

    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        bl_prev_d     = bl_prev_q;
        h_cnt_d       = h_cnt_q;
        act_cnt_d     = act_cnt_q;
        line_len_d    = line_len_q;
        v_cnt_d       = v_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_lines_d = frame_lines_q;
        active_d      = active_q;
        line_ok_d     = line_ok_q;
        good_d        = good_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;
        line_bad      = 1'b0;
        frame_good    = 1'b0;
        tmo           = 1'b0;

        if (vid.pix_en) begin
            hs_prev_d = hs_a;
            vs_prev_d = vs_a;
            bl_prev_d = vid.blank_n;
            active_d  = vid.blank_n;

            if (!vid.blank_n || !bl_prev_q) x_d = 10'd0;
            else if (x_q != 10'h3FF)        x_d = x_q + 10'd1;

            // The edge tick itself is the first tick of the new line.
            if (hs_edge) begin
                line_len_d = h_inc;
                h_cnt_d    = 11'd0;
                act_cnt_d  = {10'd0, vid.blank_n};
                line_bad   = (h_inc != H_TOT_L) || (act_cnt_q != 11'd0 && act_cnt_q != H_ACT_L);
            end else begin
                h_cnt_d = h_inc;
                tmo     = (h_inc != h_cnt_q) && (h_inc == TMO_L);
                if (vid.blank_n && act_cnt_q != 11'h7FF) act_cnt_d = act_cnt_q + 11'd1;
            end

            if (vs_edge) begin
                frame_lines_d = v_inc;
                v_cnt_d       = 10'd0;
                y_d           = 10'd0;
                frame_start_d = 1'b1;
                line_ok_d     = 1'b1;
                frame_good    = (v_inc == V_TOT_L) && line_ok_q && !line_bad && (y_inc == V_ACT_L);
            end else begin
                v_cnt_d = v_inc;
                y_d     = y_inc;
                if (line_bad) line_ok_d = 1'b0;
            end

            if (tmo) begin
                state_d    = SEARCH;
                sync_err_d = (state_q == LOCKED);
            end else begin
                case (state_q)
                    SEARCH: if (vs_edge) begin
                        state_d = ACQUIRE;
                        good_d  = 4'd0;
                    end
                    ACQUIRE: if (vs_edge) begin
                        if (frame_good) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 >= LOCK_L) state_d = LOCKED;
                        end else begin
                            good_d = 4'd0;
                        end
                    end
                    LOCKED: if (line_bad || (vs_edge && !frame_good)) begin
                        state_d    = SEARCH;
                        sync_err_d = 1'b1;
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            bl_prev_q     <= 1'b0;
            h_cnt_q       <= '0;
            act_cnt_q     <= '0;
            line_len_q    <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_lines_q <= '0;
            active_q      <= 1'b0;
            line_ok_q     <= 1'b1;
            good_q        <= '0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            bl_prev_q     <= bl_prev_d;
            h_cnt_q       <= h_cnt_d;
            act_cnt_q     <= act_cnt_d;
            line_len_q    <= line_len_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_lines_q <= frame_lines_d;
            active_q      <= active_d;
            line_ok_q     <= line_ok_d;
            good_q        <= good_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign active      = active_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

`ifdef SYNC_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif
endmodule
